// File: rtl/stack_pkg.sv
// Shared types and default sizes for the stack engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stack_pkg;

  localparam int STK_DATA_W = 10;
  localparam int STK_ADDR_W = 8;
  localparam int STK_DEPTH  = 1 << STK_ADDR_W;

  typedef enum logic [1:0] {
    PUSH = 2'd0,
    POP  = 2'd1,
    PEEK = 2'd2,
    LOAD = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/stack_engine.sv
// Purpose: downward-growing stack sequencer in front of a 1-cycle sync-read scratch RAM.
// Latency: PUSH occupies 2 cycles; POP/PEEK raise rsp_valid 2 cycles after accept; LOAD is single-cycle.
// Backpressure: cmd_ready only in IDLE; a response holds in RESP until rsp_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_op (op_t), cmd_data (push data / LOAD pointer)
//   rsp_valid/rsp_ready        popped/peeked word on rsp_data
//   mem_addr/mem_we/mem_wdata  registered RAM request; mem_rdata returns one cycle after mem_addr
//   sp, count, empty, full     pointer and occupancy status
//   err                        sticky misuse flag
// Build option: STACK_ERR_EN -- guards PUSH-when-full / POP-or-PEEK-when-empty and drives err.
//   Without it, overflowing pushes overwrite (count saturates) and empty pops read mem[sp].
module stack_engine
  import stack_pkg::*;
#(
  parameter int DATA_W = STK_DATA_W,
  parameter int ADDR_W = STK_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ONE_A    = 1;
  localparam logic [ADDR_W:0]   ONE_C    = 1;
  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              r_state;
  logic [ADDR_W-1:0]   r_sp;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;

  op_t                 w_op;
  logic                w_empty;
  logic                w_full;
  logic [ADDR_W-1:0]   w_sp_dec;
  logic [ADDR_W-1:0]   w_sp_inc;
  logic [ADDR_W-1:0]   w_load_sp;
  logic [ADDR_W-1:0]   w_load_neg;

  assign w_op       = op_t'(cmd_op);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_sp_dec   = r_sp - ONE_A;
  assign w_sp_inc   = r_sp + ONE_A;
  assign w_load_sp  = cmd_data[ADDR_W-1:0];
  // (DEPTH - sp) mod DEPTH is just the two's complement of sp in ADDR_W bits,
  // so loading 0 yields an empty stack.
  assign w_load_neg = ~w_load_sp + ONE_A;

`ifdef STACK_ERR_EN
  logic r_err;
  // Set when a guarded POP/PEEK on empty must return zero instead of RAM data.
  logic r_rd_zero;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sp        <= '0;
      r_count     <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
`ifdef STACK_ERR_EN
      r_err       <= 1'b0;
      r_rd_zero   <= 1'b0;
`endif
    end else begin
      // Write strobe lasts exactly the WRITE cycle.
      r_mem_we <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            case (w_op)
              PUSH: begin
                r_state <= WRITE;
`ifdef STACK_ERR_EN
                if (w_full) begin
                  r_err <= 1'b1;
                end else begin
                  r_sp        <= w_sp_dec;
                  r_count     <= r_count + ONE_C;
                  r_mem_addr  <= w_sp_dec;
                  r_mem_wdata <= cmd_data;
                  r_mem_we    <= 1'b1;
                end
`else
                r_sp        <= w_sp_dec;
                r_mem_addr  <= w_sp_dec;
                r_mem_wdata <= cmd_data;
                r_mem_we    <= 1'b1;
                if (!w_full) r_count <= r_count + ONE_C;
`endif
              end
              POP, PEEK: begin
                r_state <= READ;
`ifdef STACK_ERR_EN
                if (w_empty) begin
                  r_err     <= 1'b1;
                  r_rd_zero <= 1'b1;
                end else begin
                  r_rd_zero  <= 1'b0;
                  r_mem_addr <= r_sp;
                  if (w_op == POP) begin
                    r_sp    <= w_sp_inc;
                    r_count <= r_count - ONE_C;
                  end
                end
`else
                r_mem_addr <= r_sp;
                if (w_op == POP) begin
                  r_sp <= w_sp_inc;
                  if (!w_empty) r_count <= r_count - ONE_C;
                end
`endif
              end
              LOAD: begin
                r_sp    <= w_load_sp;
                r_count <= {1'b0, w_load_neg};
              end
              default: r_state <= IDLE;
            endcase
          end
        end
        WRITE: r_state <= IDLE;
        READ: begin
          r_rsp_valid <= 1'b1;
`ifdef STACK_ERR_EN
          r_rsp_data  <= r_rd_zero ? '0 : mem_rdata;
`else
          r_rsp_data  <= mem_rdata;
`endif
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;
  assign sp        = r_sp;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
`ifdef STACK_ERR_EN
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_stack_engine.sv
// Testbench for stack_engine: directed scenarios plus a randomized command stream,
// with responses checked by a scoreboard against an array-based stack model.
module tb_stack_engine;

`ifdef STACK_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [9:0] cmd_data = 10'd0;
  logic       rsp_ready = 1'b0;
  logic       cmd_ready, rsp_valid, mem_we, empty, full, err;
  logic [9:0] rsp_data, mem_wdata, mem_rdata;
  logic [7:0] mem_addr, sp;
  logic [8:0] count;

  stack_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sp(sp), .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Background RAM contents before any write.
  function automatic logic [9:0] pat(input int a);
    return 10'((a * 421 + 97) ^ (a << 3));
  endfunction

  // Scratch RAM: the engine's registered mem_addr is the RAM's address stage,
  // so the word is presented during the cycle after the address is registered.
  logic [9:0] ram [256];
  bit         ram_wr [256];
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr]    <= mem_wdata;
      ram_wr[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = ram_wr[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));

  // Reference model: stack as an array with a downward pointer.
  int         m_sp, m_count;
  bit         m_err;
  logic [9:0] m_mem [256];
  logic [9:0] exp_q [$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         rdy_mode = 2;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       rsp_ready = ($urandom_range(0, 3) != 0);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = 1'b1;
      endcase
    end
  end

  // Monitor: checks response data against the scoreboard and stability while stalled.
  logic [9:0] prev_dat;
  bit         prev_hold;
  initial begin
    prev_hold = 1'b0;
    prev_dat  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (prev_hold) chk("rsp_stable", rsp_data, prev_dat);
        if (rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else chk("rsp_data", rsp_data, exp_q.pop_front());
          prev_hold = 1'b0;
        end else begin
          prev_hold = 1'b1;
          prev_dat  = rsp_data;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic do_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_sp = 0;
    m_count = 0;
    m_err = 1'b0;
    exp_q.delete();
  endtask

  // Issue one command (called at a negedge, returns at a negedge) and check status.
  task automatic issue(input logic [1:0] op, input logic [9:0] d, input bit lat_chk);
    int n = 0;
    int old_sp;
    bit wr, rd;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 0, 1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    old_sp = m_sp;
    wr = 1'b0;
    rd = 1'b0;
    case (op)
      2'd0: begin
        if (ERR && m_count == 256) m_err = 1'b1;
        else begin
          m_sp = (m_sp + 255) % 256;
          m_mem[m_sp] = d;
          wr = 1'b1;
          if (m_count < 256) m_count++;
        end
      end
      2'd1, 2'd2: begin
        if (ERR && m_count == 0) begin
          m_err = 1'b1;
          exp_q.push_back(10'd0);
        end else begin
          exp_q.push_back(m_mem[m_sp]);
          rd = 1'b1;
          if (op == 2'd1) begin
            m_sp = (m_sp + 1) % 256;
            if (m_count > 0) m_count--;
          end
        end
      end
      default: begin
        m_sp = int'(d[7:0]);
        m_count = (256 - m_sp) % 256;
      end
    endcase
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("sp", sp, m_sp);
    chk("count", count, m_count);
    chk("empty", empty, m_count == 0);
    chk("full", full, m_count == 256);
    chk("err", err, m_err);
    chk("cmd_ready_after", cmd_ready, op == 2'd3);
    if (op == 2'd0) begin
      chk("mem_we", mem_we, wr);
      if (wr) begin
        chk("mem_addr_wr", mem_addr, m_sp);
        chk("mem_wdata", mem_wdata, d);
      end
      @(negedge clk);
      chk("mem_we_drop", mem_we, 0);
      chk("cmd_ready_push", cmd_ready, 1);
    end
    if (rd) chk("mem_addr_rd", mem_addr, old_sp);
    if ((op == 2'd1 || op == 2'd2) && lat_chk) begin
      chk("rsp_lat1", rsp_valid, 0);
      @(negedge clk);
      chk("rsp_lat2", rsp_valid, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) m_mem[i] = pat(i);

    // Reset state
    do_reset();
    chk("rst_sp", sp, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // First push lands at 0xFF
    issue(2'd0, 10'h155, 1'b0);
    chk("t1_sp", sp, 8'hFF);

    // LIFO order
    rdy_mode = 2;
    issue(2'd0, 10'h001, 1'b0);
    issue(2'd0, 10'h002, 1'b0);
    issue(2'd1, 10'h000, 1'b1);
    issue(2'd1, 10'h000, 1'b1);
    issue(2'd1, 10'h000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_sp", sp, 8'h00);
    chk("t2_empty", empty, 1);

    // Response backpressure
    do_reset();
    issue(2'd0, 10'h2C3, 1'b0);
    rdy_mode = 1;
    issue(2'd1, 10'h000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_ready", cmd_ready, 0);
    end
    rdy_mode = 2;
    @(negedge clk);
    chk("t3_rdy_cycle", cmd_ready, 0);
    @(negedge clk);
    chk("t3_released", cmd_ready, 1);
    chk("t3_valid_drop", rsp_valid, 0);

    // LOAD then PEEK
    do_reset();
    issue(2'd3, 10'h080, 1'b0);
    chk("t4_count", count, 128);
    issue(2'd2, 10'h000, 1'b1);
    chk("t4_sp", sp, 8'h80);

    // Reset while a POP is in READ
    do_reset();
    issue(2'd0, 10'h3AA, 1'b0);
    cmd_valid = 1'b1;
    cmd_op = 2'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_sp", sp, 0);
    chk("t6_count", count, 0);
    chk("t6_mem_we", mem_we, 0);
    chk("t6_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    m_sp = 0;
    m_count = 0;
    m_err = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_rsp", rsp_valid, 0);
    end

    // Randomized stream
    do_reset();
    rdy_mode = 0;
    for (int i = 0; i < 300; i++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      issue(op, 10'($urandom), 1'b1);
    end

    // Fill to DEPTH, then overflow
    rdy_mode = 2;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    do_reset();
    for (int i = 0; i < 256; i++) issue(2'd0, 10'($urandom), 1'b0);
    chk("t5_full", full, 1);
    chk("t5_sp", sp, 8'h00);
    issue(2'd0, 10'h2AB, 1'b0);
    for (int i = 0; i < 3; i++) issue(2'd1, 10'h000, 1'b1);
`ifdef STACK_ERR_EN
    do_reset();
    issue(2'd1, 10'h000, 1'b1);
    chk("t5_err_pop", err, 1);
`endif

    // Drain scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
